// File: rtl/return_scheduler.sv
// Completion return scheduler: buffers read and write completions in two circular
// queues and arbitrates them onto one registered return beat, reads first with a starvation cap.
module return_scheduler #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_cmpl_valid_i,
  input  logic [DATA_WIDTH-1:0]   rd_cmpl_data_i,
  output logic                    rd_cmpl_ready_o,
  input  logic                    wr_cmpl_valid_i,
  output logic                    wr_cmpl_ready_o,
  input  logic                    ret_ready_i,
  output logic                    read_done_o,
  output logic                    write_done_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [$clog2(DEPTH):0]  rd_level_o,
  output logic [$clog2(DEPTH):0]  wr_level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StGrantRd, StGrantWr} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
  logic [PW-1:0]         wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
  logic [DATA_WIDTH-1:0] rd_mem_q [DEPTH];
  logic                  rd_done_q, rd_done_d, wr_done_q, wr_done_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]         starve_q, starve_d;

  logic rd_empty, rd_full, wr_empty, wr_full;
  logic rd_push, wr_push, rd_pop, wr_pop, stage_load;

  assign rd_empty = (rd_wptr_q == rd_rptr_q);
  assign wr_empty = (wr_wptr_q == wr_rptr_q);
  assign rd_full  = (rd_wptr_q[AW] != rd_rptr_q[AW]) && (rd_wptr_q[AW-1:0] == rd_rptr_q[AW-1:0]);
  assign wr_full  = (wr_wptr_q[AW] != wr_rptr_q[AW]) && (wr_wptr_q[AW-1:0] == wr_rptr_q[AW-1:0]);

  // Ready depends only on current occupancy, so a full queue never accepts even when popping.
  assign rd_cmpl_ready_o = !rd_full && rst;
  assign wr_cmpl_ready_o = !wr_full && rst;
  assign rd_push         = rd_cmpl_valid_i && rd_cmpl_ready_o;
  assign wr_push         = wr_cmpl_valid_i && wr_cmpl_ready_o;

  assign stage_load = !(rd_done_q || wr_done_q) || ret_ready_i;

  always_comb begin
    state_d   = state_q;
    rd_done_d = rd_done_q;
    wr_done_d = wr_done_q;
    data_d    = data_q;
    rd_pop    = 1'b0;
    wr_pop    = 1'b0;
    if (stage_load) begin
      if (rd_empty && wr_empty) begin
        state_d   = StIdle;
        rd_done_d = 1'b0;
        wr_done_d = 1'b0;
        data_d    = '0;
      end else if (!wr_empty && (rd_empty || starve_q == StarveMax)) begin
        state_d   = StGrantWr;
        wr_pop    = 1'b1;
        rd_done_d = 1'b0;
        wr_done_d = 1'b1;
        data_d    = '0;
      end else begin
        state_d   = StGrantRd;
        rd_pop    = 1'b1;
        rd_done_d = 1'b1;
        wr_done_d = 1'b0;
        data_d    = rd_mem_q[rd_rptr_q[AW-1:0]];
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (wr_pop || wr_empty) begin
      starve_d = '0;
    end else if (rd_pop && starve_q != StarveMax) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_comb begin
    rd_wptr_d = rd_wptr_q + PW'(rd_push);
    rd_rptr_d = rd_rptr_q + PW'(rd_pop);
    wr_wptr_d = wr_wptr_q + PW'(wr_push);
    wr_rptr_d = wr_rptr_q + PW'(wr_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      rd_wptr_q <= '0;
      rd_rptr_q <= '0;
      wr_wptr_q <= '0;
      wr_rptr_q <= '0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      data_q    <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_wptr_q <= rd_wptr_d;
      rd_rptr_q <= rd_rptr_d;
      wr_wptr_q <= wr_wptr_d;
      wr_rptr_q <= wr_rptr_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      data_q    <= data_d;
      starve_q  <= starve_d;
    end
  end

  // Storage needs no reset: entries are only read between valid pointers.
  always_ff @(posedge clk) begin
    if (rd_push) begin
      rd_mem_q[rd_wptr_q[AW-1:0]] <= rd_cmpl_data_i;
    end
  end

  assign read_done_o  = rd_done_q;
  assign write_done_o = wr_done_q;
  assign data_o       = data_q;
  assign rd_level_o   = rd_wptr_q - rd_rptr_q;
  assign wr_level_o   = wr_wptr_q - wr_rptr_q;

endmodule
